// File: rtl/pcie_rx_regs.sv
// -----------------------------------------------------------------------------
// pcie_rx_regs
//
// Receive-side TLP consumer for the 16-bit VC0 receive interface of the PCIe x1
// core. Memory-write TLPs aimed at BAR0 that carry exactly one DW with a 3DW
// header are applied, byte by byte under the first-BE mask, to one of four
// 32-bit registers selected by address[3:2]. Every memory-write TLP that ends
// normally returns one posted-header credit and ceil(length/4) posted-data
// credits, whether or not it was applied.
//
// Word layout seen on rx_data (index 0 is the rx_st word):
//   w0[14:8] {fmt,type}   w1[9:0] length   w3[7:4] last BE, w3[3:0] first BE
//   w4/w5    address      w6/w7   data DW0 (first transmitted byte on [15:8])
//
// Ports
//   clk          125 MHz core clock, all logic on its rising edge
//   rstn         asynchronous active-low reset
//   rx_data      TLP word
//   rx_st        first word of a TLP
//   rx_end       last word of a TLP
//   rx_bar_hit   BAR hit vector, sampled with rx_st (bit 0 = BAR0)
//   ph_processed one-cycle pulse, one posted-header credit
//   pd_processed one-cycle pulse, pd_num posted-data credits
//   pd_num       data credit count while pd_processed, else 0 (0 encodes 256)
//   reg0..reg3   register contents (reg0 = gpio_a, reg1 = gpio_b)
//   wr_strobe    one-cycle pulse when a register write commits
// -----------------------------------------------------------------------------
module pcie_rx_regs #(
    parameter logic [31:0] RST_R0 = 32'hFFFF_FFFE,
    parameter logic [31:0] RST_R1 = 32'hFFFF_FFFE,
    parameter logic [31:0] RST_R2 = 32'h0000_0000,
    parameter logic [31:0] RST_R3 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] rx_data,
    input  logic        rx_st,
    input  logic        rx_end,
    input  logic [6:0]  rx_bar_hit,
    output logic        ph_processed,
    output logic        pd_processed,
    output logic [7:0]  pd_num,
    output logic [31:0] reg0,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] reg3,
    output logic        wr_strobe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [31:0] RST_VAL [4] = '{RST_R0, RST_R1, RST_R2, RST_R3};

    // Word index saturates here; only indices 0..7 matter for decoding and
    // long TLPs simply stay parked at this value until rx_end.
    localparam logic [3:0] IDX_SAT = 4'd8;

    // -------------------------------------------------------------------------
    // Parser state
    // -------------------------------------------------------------------------
    state_t      state_reg;
    logic [3:0]  idx_reg;        // index of the word arriving this cycle
    logic        bar0_reg;       // BAR0 hit latched at rx_st
    logic        is_mwr_reg;     // TLP is a memory write (fmt[1]=1, type=0)
    logic [9:0]  len_reg;
    logic        len_seen_reg;
    logic [3:0]  fbe_reg;
    logic [3:0]  lbe_reg;
    logic [1:0]  addr_reg;       // address[3:2], selects the register
    logic [15:0] data_lo_reg;    // w6, held until w7 completes the DW

    logic        ph_reg;
    logic        pd_reg;
    logic [7:0]  pd_num_reg;
    logic        wr_strobe_reg;

    // -------------------------------------------------------------------------
    // Decode of the current word
    // -------------------------------------------------------------------------
    logic        st_is_mwr;      // rx_st word classifies as a memory write
    logic        st_is_3dw_mwr;  // ... and has a 3DW header with data
    logic        hdr_ok;         // single-DW, BAR0, first BE set, no last BE
    logic [9:0]  len_now;        // length including the word on the bus now
    logic        len_known;
    logic [7:0]  credit_num;
    logic        credit_now;     // TLP ends this cycle and returns credits
    logic        commit_now;     // TLP ends at w7 with a decodable write
    logic [31:0] commit_data;

    always_comb begin
        st_is_mwr     = rx_data[14] && (rx_data[12:8] == 5'b00000);
        st_is_3dw_mwr = st_is_mwr && (rx_data[14:13] == 2'b10);

        hdr_ok = is_mwr_reg && bar0_reg && (len_reg == 10'd1) &&
                 (fbe_reg != 4'h0) && (lbe_reg == 4'h0);

        // A TLP that ends on w1 has still delivered its length field.
        if (idx_reg == 4'd1) begin
            len_now   = rx_data[9:0];
            len_known = 1'b1;
        end else begin
            len_now   = len_reg;
            len_known = len_seen_reg;
        end

        // ceil(length/4). Length 0 means 1024 DW: (0+3)>>2 = 0, and lengths
        // 1021..1023 give 256 which also truncates to 0, the core's code for
        // 256 credits.
        if (len_known) begin
            credit_num = 8'((11'(len_now) + 11'd3) >> 2);
        end else begin
            credit_num = 8'd1;
        end

        // A new rx_st abandons whatever is in flight without credits.
        credit_now = (state_reg != S_IDLE) && rx_end && !rx_st && is_mwr_reg;
        commit_now = (state_reg == S_DATA) && (idx_reg == 4'd7) && rx_end && !rx_st;

        // Byte 0 of the DW is the first transmitted byte (w6[15:8]).
        commit_data = {rx_data[7:0], rx_data[15:8],
                       data_lo_reg[7:0], data_lo_reg[15:8]};
    end

    // -------------------------------------------------------------------------
    // FSM, header capture and registered pulse outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            idx_reg       <= 4'd0;
            bar0_reg      <= 1'b0;
            is_mwr_reg    <= 1'b0;
            len_reg       <= 10'd0;
            len_seen_reg  <= 1'b0;
            fbe_reg       <= 4'h0;
            lbe_reg       <= 4'h0;
            addr_reg      <= 2'd0;
            data_lo_reg   <= 16'h0000;
            ph_reg        <= 1'b0;
            pd_reg        <= 1'b0;
            pd_num_reg    <= 8'd0;
            wr_strobe_reg <= 1'b0;
        end else begin
            ph_reg        <= credit_now;
            pd_reg        <= credit_now;
            pd_num_reg    <= credit_now ? credit_num : 8'd0;
            wr_strobe_reg <= commit_now;

            if (state_reg != S_IDLE) begin
                if (idx_reg != IDX_SAT) begin
                    idx_reg <= idx_reg + 4'd1;
                end
                case (idx_reg)
                    4'd1: begin
                        len_reg      <= rx_data[9:0];
                        len_seen_reg <= 1'b1;
                    end
                    4'd3: begin
                        lbe_reg <= rx_data[7:4];
                        fbe_reg <= rx_data[3:0];
                    end
                    4'd5: addr_reg    <= rx_data[3:2];
                    4'd6: data_lo_reg <= rx_data;
                    default: ;
                endcase
            end

            case (state_reg)
                S_IDLE: ;
                S_HDR: begin
                    if (rx_end) begin
                        state_reg <= S_IDLE;
                    end else if (idx_reg == 4'd5) begin
                        state_reg <= hdr_ok ? S_DATA : S_DROP;
                    end
                end
                S_DATA: begin
                    if (rx_end) begin
                        state_reg <= S_IDLE;
                    end else if (idx_reg == 4'd7) begin
                        // Payload longer than the single DW we accept.
                        state_reg <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (rx_end) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // rx_st wins over everything above, from any state: the word on
            // the bus becomes w0 of a new TLP.
            if (rx_st) begin
                bar0_reg     <= rx_bar_hit[0];
                is_mwr_reg   <= st_is_mwr;
                len_seen_reg <= 1'b0;
                idx_reg      <= 4'd1;
                if (rx_end) begin
                    state_reg <= S_IDLE;
                end else if (st_is_3dw_mwr) begin
                    state_reg <= S_HDR;
                end else begin
                    // 4DW writes and non-writes can never commit; just wait
                    // for rx_end (credits still tracked through is_mwr_reg).
                    state_reg <= S_DROP;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register bank: one flop group per register, byte-lane write enables
    // -------------------------------------------------------------------------
    logic [31:0] reg_val [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [31:0] r_reg;
            logic        sel;

            assign sel = commit_now && (addr_reg == 2'(gi));

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_reg <= RST_VAL[gi];
                end else if (sel) begin
                    for (int b = 0; b < 4; b++) begin
                        if (fbe_reg[b]) begin
                            r_reg[8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_val[gi] = r_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -------------------------------------------------------------------------
    assign reg0         = reg_val[0];
    assign reg1         = reg_val[1];
    assign reg2         = reg_val[2];
    assign reg3         = reg_val[3];
    assign ph_processed = ph_reg;
    assign pd_processed = pd_reg;
    assign pd_num       = pd_num_reg;
    assign wr_strobe    = wr_strobe_reg;

    // Only BAR0 is decoded; the other hit bits are intentionally ignored.
    logic unused_bar_hits;
    assign unused_bar_hits = &{1'b0, rx_bar_hit[6:1]};

endmodule
